// File: rtl/result_writeback_if.sv
// Result writeback bus: command/status, result-buffer read port and DMA write port.
// "slave" is the writeback engine's view of the bus.
// "master" is the view of whatever drives the engine.
interface result_writeback_if #(
    parameter int DATA_W = 256
);
    logic                  start;
    logic [31:0]           addr_base_c;
    logic [31:0]           m;
    logic [31:0]           n;
    logic                  tile_valid;
    logic                  tile_ack;
    logic                  buf_rd_en;
    logic [15:0]           buf_rd_addr;
    logic [DATA_W-1:0]     buf_rd_data;
    logic                  dma_start;
    logic [31:0]           dma_addr;
    logic [DATA_W-1:0]     dma_data;
    logic [DATA_W/8-1:0]   dma_strb;
    logic                  dma_done;
    logic                  busy;
    logic                  done;

    modport slave (
        input  start, addr_base_c, m, n, tile_valid, buf_rd_data, dma_done,
        output tile_ack, buf_rd_en, buf_rd_addr, dma_start, dma_addr, dma_data,
               dma_strb, busy, done
    );

    modport master (
        output start, addr_base_c, m, n, tile_valid, buf_rd_data, dma_done,
        input  tile_ack, buf_rd_en, buf_rd_addr, dma_start, dma_addr, dma_data,
               dma_strb, busy, done
    );
endinterface

// File: rtl/result_writeback.sv
// result_writeback: drains finished SIZE x SIZE C tiles from the result buffer.
// It issues one DMA write per beat into a row-major int32 M x N matrix.
// Tiles are visited m-outer / n-inner. Rows beyond m are skipped.
// Columns beyond n are masked with byte strobes.
// Optional feature macro WB_RELU_EN: zero negative elements on the way out
// (ReLU at writeback). This adds no cycles.
module result_writeback #(
    parameter int SIZE   = 16,
    parameter int DATA_W = 256,
    parameter int ELEM_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    result_writeback_if.slave bus
);
    localparam int EPB    = DATA_W / ELEM_W;   // elements per beat
    localparam int BPR    = SIZE / EPB;        // beats per tile row
    localparam int BPE    = ELEM_W / 8;        // bytes per element
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE, WAIT_TILE, RD_BUF, ISSUE, WAIT_DONE, ADVANCE, FINISH
    } state_t;

    state_t              state_reg;
    logic [31:0]         base_reg, m_reg, n_reg;
    logic [31:0]         m_cnt_reg, n_cnt_reg;
    logic [7:0]          row_cnt_reg, beat_cnt_reg;

    logic                tile_ack_reg, buf_rd_en_reg, dma_start_reg, done_reg;
    logic [15:0]         buf_rd_addr_reg;
    logic [31:0]         dma_addr_reg;
    logic [DATA_W-1:0]   dma_data_reg;
    logic [STRB_W-1:0]   dma_strb_reg;

    // First column of the current beat. Compares use 33 bits so that n near 2^32 cannot wrap.
    logic [32:0]         col_base_w, next_col_w;
    logic [31:0]         row_abs, elem_idx, addr_next;
    logic [EPB-1:0]      elem_valid;
    logic [STRB_W-1:0]   strb_next;
    logic [DATA_W-1:0]   data_next;
    logic                beat_more, row_more, n_wrap, m_last;

    assign col_base_w = 33'(n_cnt_reg) + 33'(beat_cnt_reg) * 33'(EPB);
    assign next_col_w = col_base_w + 33'(EPB);

    // Byte address of the current beat. The arithmetic intentionally wraps mod 2^32.
    assign row_abs   = m_cnt_reg + 32'(row_cnt_reg);
    assign elem_idx  = row_abs * n_reg + n_cnt_reg + 32'(beat_cnt_reg) * 32'(EPB);
    assign addr_next = base_reg + elem_idx * 32'(BPE);

    // Next position inside the tile. A beat with no valid column is never visited.
    // A row beyond m is never visited either.
    assign beat_more = (32'(beat_cnt_reg) + 32'd1 < 32'(BPR)) && (next_col_w < 33'(n_reg));
    assign row_more  = (32'(row_cnt_reg) + 32'd1 < 32'(SIZE)) &&
                       (33'(m_cnt_reg) + 33'(row_cnt_reg) + 33'd1 < 33'(m_reg));
    assign n_wrap    = (33'(n_cnt_reg) + 33'(SIZE)) >= 33'(n_reg);
    assign m_last    = (33'(m_cnt_reg) + 33'(SIZE)) >= 33'(m_reg);

    generate
        for (genvar gi = 0; gi < EPB; gi++) begin : g_strb
            // One strobe byte per element byte, set only for columns below n.
            assign elem_valid[gi] = (col_base_w + 33'(gi)) < 33'(n_reg);
            assign strb_next[gi*BPE +: BPE] = {BPE{elem_valid[gi]}};
        end
    endgenerate

`ifdef WB_RELU_EN
    generate
        for (genvar gi = 0; gi < EPB; gi++) begin : g_relu
            // Negative elements are written as zero.
            assign data_next[gi*ELEM_W +: ELEM_W] =
                bus.buf_rd_data[gi*ELEM_W + ELEM_W - 1] ? '0 : bus.buf_rd_data[gi*ELEM_W +: ELEM_W];
        end
    endgenerate
`else
    assign data_next = bus.buf_rd_data;
`endif

    // Control FSM. All outputs are registered and pulse outputs default low every cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg       <= IDLE;
            base_reg        <= '0;
            m_reg           <= '0;
            n_reg           <= '0;
            m_cnt_reg       <= '0;
            n_cnt_reg       <= '0;
            row_cnt_reg     <= '0;
            beat_cnt_reg    <= '0;
            tile_ack_reg    <= 1'b0;
            buf_rd_en_reg   <= 1'b0;
            buf_rd_addr_reg <= '0;
            dma_start_reg   <= 1'b0;
            dma_addr_reg    <= '0;
            dma_data_reg    <= '0;
            dma_strb_reg    <= '0;
            done_reg        <= 1'b0;
        end else begin
            tile_ack_reg  <= 1'b0;
            buf_rd_en_reg <= 1'b0;
            dma_start_reg <= 1'b0;
            done_reg      <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        base_reg     <= bus.addr_base_c;
                        m_reg        <= bus.m;
                        n_reg        <= bus.n;
                        m_cnt_reg    <= '0;
                        n_cnt_reg    <= '0;
                        row_cnt_reg  <= '0;
                        beat_cnt_reg <= '0;
                        if (bus.m == 32'd0 || bus.n == 32'd0) begin
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            state_reg <= WAIT_TILE;
                        end
                    end
                end
                WAIT_TILE: begin
                    // Counters are already at {0,0} for a fresh tile.
                    if (bus.tile_valid) begin
                        buf_rd_en_reg   <= 1'b1;
                        buf_rd_addr_reg <= {row_cnt_reg, beat_cnt_reg};
                        state_reg       <= RD_BUF;
                    end
                end
                RD_BUF: begin
                    state_reg <= ISSUE;
                end
                ISSUE: begin
                    // Read data is valid this cycle. It is held in the dma_* registers until the next beat.
                    dma_data_reg  <= data_next;
                    dma_addr_reg  <= addr_next;
                    dma_strb_reg  <= strb_next;
                    dma_start_reg <= 1'b1;
                    state_reg     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (bus.dma_done) begin
                        state_reg <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (beat_more) begin
                        beat_cnt_reg    <= beat_cnt_reg + 8'd1;
                        buf_rd_en_reg   <= 1'b1;
                        buf_rd_addr_reg <= {row_cnt_reg, beat_cnt_reg + 8'd1};
                        state_reg       <= RD_BUF;
                    end else if (row_more) begin
                        row_cnt_reg     <= row_cnt_reg + 8'd1;
                        beat_cnt_reg    <= '0;
                        buf_rd_en_reg   <= 1'b1;
                        buf_rd_addr_reg <= {row_cnt_reg + 8'd1, 8'd0};
                        state_reg       <= RD_BUF;
                    end else begin
                        tile_ack_reg <= 1'b1;
                        row_cnt_reg  <= '0;
                        beat_cnt_reg <= '0;
                        if (n_wrap) begin
                            n_cnt_reg <= '0;
                            m_cnt_reg <= m_cnt_reg + 32'(SIZE);
                        end else begin
                            n_cnt_reg <= n_cnt_reg + 32'(SIZE);
                        end
                        if (m_last && n_wrap) begin
                            done_reg  <= 1'b1;
                            state_reg <= FINISH;
                        end else begin
                            state_reg <= WAIT_TILE;
                        end
                    end
                end
                FINISH: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.tile_ack    = tile_ack_reg;
    assign bus.buf_rd_en   = buf_rd_en_reg;
    assign bus.buf_rd_addr = buf_rd_addr_reg;
    assign bus.dma_start   = dma_start_reg;
    assign bus.dma_addr    = dma_addr_reg;
    assign bus.dma_data    = dma_data_reg;
    assign bus.dma_strb    = dma_strb_reg;
    assign bus.done        = done_reg;
    assign bus.busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_result_writeback.sv
// Directed testbench for result_writeback.
// The bench models the result buffer and a DMA target that completes each write two cycles later.
// Expected addresses, strobes and data are hand-derived for each directed job.
`timescale 1ns/1ps
module tb_result_writeback;
    localparam int DATA_W = 256;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    result_writeback_if #(.DATA_W(DATA_W)) wb_if();

    result_writeback #(.SIZE(16), .DATA_W(DATA_W), .ELEM_W(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (wb_if)
    );

    int checks = 0;
    int errors = 0;

    logic neg_mode;
    logic resp_en;
    logic stray_done;
    logic resp_done = 1'b0;
    int   resp_cnt  = 0;
    assign wb_if.dma_done = resp_done | stray_done;

    logic [31:0]       log_addr [0:255];
    logic [31:0]       log_strb [0:255];
    logic [DATA_W-1:0] log_data [0:255];
    int beat_total = 0;
    int ack_total  = 0;
    int done_total = 0;

    // Result buffer contents: each element encodes {row, beat, 0x5A, element}.
    function automatic logic [DATA_W-1:0] buf_word(input logic [15:0] a);
        logic [DATA_W-1:0] w;
        for (int e = 0; e < 8; e++) w[e*32 +: 32] = {a[15:8], a[7:0], 8'h5A, 8'(e)};
        if (neg_mode) begin
            w[31:0]  = 32'hFFFF_FFF0;
            w[63:32] = 32'h0000_0005;
        end
        return w;
    endfunction

    // Registered buffer read: data appears one cycle after buf_rd_en.
    always @(posedge clk) begin
        if (wb_if.buf_rd_en) wb_if.buf_rd_data <= buf_word(wb_if.buf_rd_addr);
    end

    // Log every DMA beat and count tile_ack / done pulses.
    always @(negedge clk) begin
        if (wb_if.dma_start) begin
            if (beat_total < 256) begin
                log_addr[beat_total] <= wb_if.dma_addr;
                log_strb[beat_total] <= wb_if.dma_strb;
                log_data[beat_total] <= wb_if.dma_data;
            end
            beat_total <= beat_total + 1;
        end
        if (wb_if.tile_ack) ack_total  <= ack_total + 1;
        if (wb_if.done)     done_total <= done_total + 1;
    end

    // DMA target: dma_done pulses for one cycle, two cycles after dma_start.
    always @(negedge clk) begin
        if (resp_cnt > 0) begin
            resp_done <= (resp_cnt == 1);
            resp_cnt  <= resp_cnt - 1;
        end else begin
            resp_done <= 1'b0;
        end
        if (wb_if.dma_start && resp_en) resp_cnt <= 2;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [31:0] mm, input logic [31:0] nn);
        wb_if.addr_base_c = base;
        wb_if.m           = mm;
        wb_if.n           = nn;
        wb_if.start       = 1'b1;
        tick();
        wb_if.start       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int budget);
        int k = 0;
        while (done_total == d0 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 256'(done_total != d0), 256'd1);
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_busy"},     256'(wb_if.busy),        256'd0);
        chk({tag, "_done"},     256'(wb_if.done),        256'd0);
        chk({tag, "_tack"},     256'(wb_if.tile_ack),    256'd0);
        chk({tag, "_rden"},     256'(wb_if.buf_rd_en),   256'd0);
        chk({tag, "_rdaddr"},   256'(wb_if.buf_rd_addr), 256'd0);
        chk({tag, "_dstart"},   256'(wb_if.dma_start),   256'd0);
        chk({tag, "_daddr"},    256'(wb_if.dma_addr),    256'd0);
        chk({tag, "_ddata"},    256'(wb_if.dma_data),    256'd0);
        chk({tag, "_dstrb"},    256'(wb_if.dma_strb),    256'd0);
    endtask

    initial begin
        int b0, a0, d0, row, bt;
        logic [31:0] exp_addr, exp_strb;
        logic [DATA_W-1:0] exp_data;

        wb_if.start = 1'b0; wb_if.addr_base_c = '0; wb_if.m = '0; wb_if.n = '0;
        wb_if.tile_valid = 1'b0;
        stray_done = 1'b0; neg_mode = 1'b0; resp_en = 1'b1;
        rstn = 1'b0;
        repeat (3) tick();
        chk_outs_zero("reset");
        rstn = 1'b1;
        tick();

        // T1: one full 16x16 tile. tile_valid is held back, then a second start and a stray dma_done are injected.
        b0 = beat_total; a0 = ack_total; d0 = done_total;
        pulse_start(32'h1000, 32'd16, 32'd16);
        repeat (5) tick();
        chk("t1_busy_wait", 256'(wb_if.busy), 256'd1);
        pulse_start(32'h0, 32'd0, 32'd5);
        stray_done = 1'b1; tick(); stray_done = 1'b0;
        repeat (3) tick();
        chk("t1_no_beats_wo_tile", 256'(beat_total - b0), 256'd0);
        chk("t1_restart_ignored", 256'(done_total - d0), 256'd0);
        wb_if.tile_valid = 1'b1;
        wait_done("t1_done", d0, 2000);
        wb_if.tile_valid = 1'b0;
        repeat (3) tick();
        chk("t1_beats", 256'(beat_total - b0), 256'd32);
        chk("t1_acks",  256'(ack_total - a0),  256'd1);
        chk("t1_dones", 256'(done_total - d0), 256'd1);
        chk("t1_idle",  256'(wb_if.busy),      256'd0);
        for (int i = 0; i < 32; i++) begin
            row = i / 2; bt = i % 2;
            exp_addr = 32'h1000 + 32'(row) * 32'd64 + 32'(bt) * 32'd32;
            exp_data = buf_word({8'(row), 8'(bt)});
            chk($sformatf("t1_addr%0d", i), 256'(log_addr[b0 + i]), 256'(exp_addr));
            chk($sformatf("t1_strb%0d", i), 256'(log_strb[b0 + i]), 256'h FFFF_FFFF);
            chk($sformatf("t1_data%0d", i), 256'(log_data[b0 + i]), 256'(exp_data));
        end

        // T2: column edge. n=12, so beat 1 of each row carries 4 valid elements.
        b0 = beat_total; a0 = ack_total; d0 = done_total;
        wb_if.tile_valid = 1'b1;
        pulse_start(32'h2000, 32'd16, 32'd12);
        wait_done("t2_done", d0, 2000);
        repeat (3) tick();
        chk("t2_beats", 256'(beat_total - b0), 256'd32);
        chk("t2_acks",  256'(ack_total - a0),  256'd1);
        for (int i = 0; i < 32; i++) begin
            row = i / 2; bt = i % 2;
            exp_addr = 32'h2000 + 32'(row) * 32'd48 + 32'(bt) * 32'd32;
            exp_strb = (bt == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            chk($sformatf("t2_addr%0d", i), 256'(log_addr[b0 + i]), 256'(exp_addr));
            chk($sformatf("t2_strb%0d", i), 256'(log_strb[b0 + i]), 256'(exp_strb));
        end

        // T3: row and column edge. m=3 and n=5 give three beats.
        b0 = beat_total; a0 = ack_total; d0 = done_total;
        pulse_start(32'h3000, 32'd3, 32'd5);
        wait_done("t3_done", d0, 2000);
        repeat (3) tick();
        chk("t3_beats", 256'(beat_total - b0), 256'd3);
        chk("t3_acks",  256'(ack_total - a0),  256'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_addr%0d", i), 256'(log_addr[b0 + i]), 256'(32'h3000 + 32'(i) * 32'd20));
            chk($sformatf("t3_strb%0d", i), 256'(log_strb[b0 + i]), 256'h000F_FFFF);
        end

        // T4: 32x32 matrix as four tiles in order (0,0), (0,16), (16,0), (16,16).
        b0 = beat_total; a0 = ack_total; d0 = done_total;
        pulse_start(32'h4000, 32'd32, 32'd32);
        wait_done("t4_done", d0, 4000);
        repeat (3) tick();
        chk("t4_beats", 256'(beat_total - b0), 256'd128);
        chk("t4_acks",  256'(ack_total - a0),  256'd4);
        chk("t4_dones", 256'(done_total - d0), 256'd1);
        chk("t4_tile0", 256'(log_addr[b0]),       256'h4000);
        chk("t4_tile1", 256'(log_addr[b0 + 32]),  256'h4040);
        chk("t4_tile2", 256'(log_addr[b0 + 64]),  256'h4800);
        chk("t4_tile3", 256'(log_addr[b0 + 96]),  256'h4840);
        chk("t4_last",  256'(log_addr[b0 + 127]), 256'h4FE0);
        wb_if.tile_valid = 1'b0;

        // T5: degenerate sizes. done follows start by one cycle and no beat is issued.
        b0 = beat_total;
        pulse_start(32'h5000, 32'd0, 32'd16);
        chk("t5m_done_pulse", 256'(wb_if.done), 256'd1);
        tick();
        chk("t5m_done_low", 256'(wb_if.done), 256'd0);
        chk("t5m_idle",     256'(wb_if.busy), 256'd0);
        pulse_start(32'h5000, 32'd16, 32'd0);
        chk("t5n_done_pulse", 256'(wb_if.done), 256'd1);
        tick();
        chk("t5n_done_low", 256'(wb_if.done), 256'd0);
        repeat (3) tick();
        chk("t5_no_beats", 256'(beat_total - b0), 256'd0);

        // T6a: ReLU. Element 0 is negative and element 1 is positive.
        b0 = beat_total; d0 = done_total;
        neg_mode = 1'b1;
        wb_if.tile_valid = 1'b1;
        pulse_start(32'h5000, 32'd1, 32'd2);
        wait_done("t6r_done", d0, 500);
        repeat (3) tick();
        neg_mode = 1'b0;
        chk("t6r_beats", 256'(beat_total - b0), 256'd1);
        chk("t6r_strb",  256'(log_strb[b0]), 256'h0000_00FF);
        chk("t6r_addr",  256'(log_addr[b0]), 256'h5000);
`ifdef WB_RELU_EN
        chk("t6r_elem0", 256'(log_data[b0][31:0]), 256'h0);
`else
        chk("t6r_elem0", 256'(log_data[b0][31:0]), 256'hFFFF_FFF0);
`endif
        chk("t6r_elem1", 256'(log_data[b0][63:32]), 256'h5);
        chk("t6r_elem2", 256'(log_data[b0][95:64]), 256'h0000_5A02);

        // T6b: asynchronous reset while a beat is outstanding in WAIT_DONE.
        resp_en = 1'b0;
        b0 = beat_total;
        pulse_start(32'h6000, 32'd16, 32'd16);
        for (int k = 0; k < 50 && beat_total == b0; k++) tick();
        chk("t6_first_beat", 256'(beat_total - b0), 256'd1);
        repeat (2) tick();
        chk("t6_busy_before", 256'(wb_if.busy), 256'd1);
        #2 rstn = 1'b0;
        #1;
        chk_outs_zero("t6_async");
        tick();
        rstn = 1'b1;
        wb_if.tile_valid = 1'b0;
        repeat (10) tick();
        chk("t6_no_reissue", 256'(beat_total - b0), 256'd1);
        chk("t6_idle_after", 256'(wb_if.busy), 256'd0);
        resp_en = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
